// File: rtl/llmint_input_packer.sv
// rtl/llmint_input_packer.sv - scalar-to-vector packer with per-vector outlier counting
module llmint_input_packer #(
    parameter int PRECISION       = 16,
    parameter int TENSOR_SIZE_DIM = 8,
    parameter int HIGH_SLOTS      = 2,
    parameter int THRESHOLD       = 6
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [PRECISION-1:0]                            data_in,
    input  logic                                            data_in_valid,
    output logic                                            data_in_ready,
    output logic [TENSOR_SIZE_DIM-1:0][PRECISION-1:0]       data_out,
    output logic                                            data_out_valid,
    input  logic                                            data_out_ready,
    output logic [$clog2(TENSOR_SIZE_DIM+1)-1:0]            outlier_count,
    output logic                                            outlier_overflow
);

    localparam int CW = $clog2(TENSOR_SIZE_DIM + 1);
    localparam int IW = $clog2(TENSOR_SIZE_DIM);
    localparam logic [IW-1:0]        LAST_IDX = IW'(TENSOR_SIZE_DIM - 1);
    localparam logic [PRECISION:0]   THR      = (PRECISION + 1)'(THRESHOLD);

    logic [TENSOR_SIZE_DIM-1:0][PRECISION-1:0] asm_q, asm_d;
    logic [TENSOR_SIZE_DIM-1:0][PRECISION-1:0] out_q, out_d;
    logic [IW-1:0] widx_q, widx_d;
    logic          full_q, full_d;
    logic [CW-1:0] acc_q, acc_d, acc_sum;
    logic          valid_q, valid_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    logic               in_fire, out_fire, last_slot, out_free, is_outlier;
    logic [PRECISION:0] data_sx, data_abs;

    // Magnitude in one extra bit so the most-negative input does not wrap.
    always_comb begin
        data_sx    = {data_in[PRECISION-1], data_in};
        data_abs   = data_sx[PRECISION] ? (~data_sx + (PRECISION + 1)'(1)) : data_sx;
        is_outlier = data_abs > THR;
    end

    always_comb begin
        in_fire   = data_in_valid & ~full_q;
        out_fire  = valid_q & data_out_ready;
        last_slot = in_fire & (widx_q == LAST_IDX);
        out_free  = ~valid_q | out_fire;
        acc_sum   = acc_q + CW'(is_outlier);

        asm_d   = asm_q;
        widx_d  = widx_q;
        full_d  = full_q;
        acc_d   = acc_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;

        if (out_fire) begin
            valid_d = 1'b0;
        end

        if (in_fire) begin
            asm_d[widx_q] = data_in;
            acc_d         = acc_sum;
            widx_d        = last_slot ? '0 : widx_q + IW'(1);
            if (last_slot) begin
                if (out_free) begin
                    out_d   = asm_d;
                    cnt_d   = acc_sum;
                    valid_d = 1'b1;
                    acc_d   = '0;
                end else begin
                    full_d = 1'b1;
                end
            end
        end

        // A held vector (input side stalled) drains on the output transfer.
        if (full_q && out_fire) begin
            out_d   = asm_q;
            cnt_d   = acc_q;
            valid_d = 1'b1;
            acc_d   = '0;
            full_d  = 1'b0;
        end

        ovf_d = 32'(cnt_d) > 32'(HIGH_SLOTS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q   <= '0;
            widx_q  <= '0;
            full_q  <= 1'b0;
            acc_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            asm_q   <= asm_d;
            widx_q  <= widx_d;
            full_q  <= full_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_in_ready    = ~full_q;
    assign data_out         = out_q;
    assign data_out_valid   = valid_q;
    assign outlier_count    = cnt_q;
    assign outlier_overflow = ovf_q;

endmodule
